// File: rtl/axi_bti_pkg.sv
// rtl/axi_bti_pkg.sv - shared register map, bit indices and FSM states for the BTI sensor slave
package axi_bti_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_WINDOW = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CONT   = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur, input logic [31:0] wdata,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bti_edge_counter.sv
// rtl/bti_edge_counter.sv - synchronised ring-oscillator edge counter gated by an ACLK window
module bti_edge_counter
  import axi_bti_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sensor_in,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [CNT_WIDTH-1:0] window,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 ovf
);

  state_e               state_q, state_d;
  logic [2:0]           sync_q, sync_d;
  logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_WIDTH-1:0] result_q, result_d;
  logic [CNT_WIDTH-1:0] edge_next;
  logic                 edge_det, edge_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    // sync_q[1] is the synchronised level, sync_q[2] its previous value
    sync_d     = {sync_q[1:0], sensor_in};
    edge_det   = sync_q[1] & ~sync_q[2];
    edge_full  = &edge_cnt_q;
    edge_next  = edge_full ? edge_cnt_q : edge_cnt_q + CNT_WIDTH'(edge_det);
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    result_d   = result_q;
    ovf        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          win_cnt_d  = window;
          edge_cnt_d = '0;
        end
      end
      S_RUN: begin
        // win_cnt of 0 only occurs for a zero-length window, which reports no edges
        if (win_cnt_q <= CNT_WIDTH'(1)) begin
          state_d  = S_DONE;
          result_d = (win_cnt_q == '0) ? '0 : edge_next;
          ovf      = (win_cnt_q != '0) & edge_full & edge_det;
        end else begin
          win_cnt_d  = win_cnt_q - CNT_WIDTH'(1);
          edge_cnt_d = edge_next;
          ovf        = edge_full & edge_det;
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d    = S_RUN;
          win_cnt_d  = window;
          edge_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done_pulse = (state_q == S_DONE);
  assign result     = result_q;

endmodule

// File: rtl/axi_bti_sensor_slave.sv
// rtl/axi_bti_sensor_slave.sv - AXI4-Lite register slave wrapping the BTI edge-count measurement
module axi_bti_sensor_slave
  import axi_bti_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              sensor_in,
  output logic                              irq
);

  logic                          aw_hs, ar_hs, start_pulse;
  logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic                          irq_en_q, irq_en_d, cont_q, cont_d;
  logic                          done_q, done_d, ovf_q, ovf_d, irq_q, irq_d;
  logic                          clr_done, clr_ovf;
  logic [31:0]                   window_q, window_d;
  logic                          busy, done_pulse, ovf_pulse;
  logic [CNT_WIDTH-1:0]          result;
  logic [1:0]                    waddr, raddr;
  logic                          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign waddr     = S_AXI_AWADDR[3:2];
  assign raddr     = S_AXI_ARADDR[3:2];

  // Readies are combinational but gated by reset so nothing handshakes while ARESET is high
  assign aw_hs = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~ARESET;
  assign ar_hs = S_AXI_ARVALID & ~rvalid_q & ~ARESET;

  assign S_AXI_AWREADY = aw_hs;
  assign S_AXI_WREADY  = aw_hs;
  assign S_AXI_ARREADY = ar_hs;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign irq           = irq_q;

  bti_edge_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
    .clk        (ACLK),
    .rst        (ARESET),
    .sensor_in  (sensor_in),
    .start      (start_pulse),
    .continuous (cont_q),
    .window     (CNT_WIDTH'(window_q)),
    .busy       (busy),
    .done_pulse (done_pulse),
    .result     (result),
    .ovf        (ovf_pulse)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_en_q <= 1'b0;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      window_q <= '0;
    end else begin
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      irq_en_q <= irq_en_d;
      cont_q   <= cont_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      window_q <= window_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (raddr)
      REG_CTRL: begin
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
        rd_mux[CTRL_CONT]   = cont_q;
      end
      REG_WINDOW: rd_mux = C_S_AXI_DATA_WIDTH'(window_q);
      REG_RESULT: rd_mux = C_S_AXI_DATA_WIDTH'(result);
      REG_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done_q;
        rd_mux[STAT_OVF]  = ovf_q;
      end
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    bvalid_d    = aw_hs ? 1'b1 : (S_AXI_BREADY ? 1'b0 : bvalid_q);
    rvalid_d    = ar_hs ? 1'b1 : (S_AXI_RREADY ? 1'b0 : rvalid_q);
    rdata_d     = ar_hs ? rd_mux : rdata_q;
    irq_en_d    = irq_en_q;
    cont_d      = cont_q;
    window_d    = window_q;
    start_pulse = 1'b0;
    clr_done    = 1'b0;
    clr_ovf     = 1'b0;
    if (aw_hs) begin
      case (waddr)
        REG_CTRL: begin
          if (S_AXI_WSTRB[0]) begin
            start_pulse = S_AXI_WDATA[CTRL_START];
            irq_en_d    = S_AXI_WDATA[CTRL_IRQ_EN];
            cont_d      = S_AXI_WDATA[CTRL_CONT];
          end
        end
        REG_WINDOW: window_d = apply_wstrb(window_q, S_AXI_WDATA, S_AXI_WSTRB);
        REG_STATUS: begin
          clr_done = S_AXI_WSTRB[0] & S_AXI_WDATA[STAT_DONE];
          clr_ovf  = S_AXI_WSTRB[0] & S_AXI_WDATA[STAT_OVF];
        end
        default: ;
      endcase
    end
    // A completion in the same cycle as a W1C clear keeps the flag set
    done_d = done_pulse | (done_q & ~clr_done);
    ovf_d  = ovf_pulse | (ovf_q & ~clr_ovf);
    irq_d  = done_q & irq_en_q;
  end

endmodule

// File: tb/tb_axi_bti_sensor_slave.sv
// tb/tb_axi_bti_sensor_slave.sv - self-checking bench for the BTI sensor AXI4-Lite slave
module tb_axi_bti_sensor_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        sensor_in, irq;

  int tot = 0;
  int bad = 0;
  int sens_half = 0;
  int sens_cnt = 0;

  logic [31:0] m_window, m_result;

  always #5 aclk = ~aclk;

  axi_bti_sensor_slave dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .sensor_in(sensor_in), .irq(irq)
  );

  // Square wave with period 2*sens_half cycles: any k*period window holds exactly k rising edges
  initial begin
    sensor_in = 1'b0;
    forever begin
      @(posedge aclk);
      #2;
      if (sens_half > 0) begin
        sens_cnt++;
        if (sens_cnt >= sens_half) begin
          sens_cnt  = 0;
          sensor_in = ~sensor_in;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int n;
    @(negedge aclk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); #1; n++; end
    tot++;
    if (awready !== 1'b1) begin bad++; $display("FAIL wr_accept addr=%h got=%b required=1", addr, awready); end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    resp = bresp;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); #1; n++; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge aclk); #1; n++; end
    tot++;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL rd_timeout addr=%h got=%b required=1", addr, rvalid); end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin @(posedge aclk); #1; n++; end
    tot++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b required=1", irq); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge aclk);
    #1;
    tot++;
    if ({awready, wready, bvalid, arready, rvalid, rdata, irq, bresp, rresp} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h required=0", {awready, wready, bvalid, arready, rvalid, rdata, irq});
    end
    @(negedge aclk); areset = 1'b0;
    m_window = '0; m_result = '0;
    for (int a = 0; a < 4; a++) begin
      axi_read(4'(a * 4), d, r);
      tot++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h required=0", a, d); end
    end
  endtask

  task automatic test_rw_window();
    logic [31:0] d;
    logic [1:0]  r, b;
    axi_write(4'h4, 32'h0000_0010, 4'hF, b);
    m_window = 32'h10;
    axi_read(4'h4, d, r);
    tot++; if (d !== m_window) begin bad++; $display("FAIL rw_window got=%h required=%h", d, m_window); end
    tot++; if (r !== 2'b00) begin bad++; $display("FAIL rw_rresp got=%b required=00", r); end
    tot++; if (b !== 2'b00) begin bad++; $display("FAIL rw_bresp got=%b required=00", b); end
  endtask

  task automatic measure(input int half, input int periods, input string tag);
    logic [31:0] d;
    logic [1:0]  r, b;
    sens_half = half;
    repeat (20) @(posedge aclk);
    m_window = 32'(periods * 2 * half);
    m_result = 32'(periods);
    axi_write(4'h4, m_window, 4'hF, b);
    axi_write(4'h0, 32'h3, 4'hF, b);
    axi_read(4'h0, d, r);
    tot++; if (d !== 32'h2) begin bad++; $display("FAIL %s ctrl_rd got=%h required=2", tag, d); end
    wait_irq(m_window + 100);
    axi_read(4'h8, d, r);
    tot++; if (d !== m_result) begin bad++; $display("FAIL %s result got=%0d required=%0d", tag, d, m_result); end
    axi_read(4'hC, d, r);
    tot++; if (d !== 32'h2) begin bad++; $display("FAIL %s status_done got=%h required=2", tag, d); end
    axi_write(4'hC, 32'h2, 4'hF, b);
    repeat (2) @(posedge aclk);
    #1;
    tot++; if (irq !== 1'b0) begin bad++; $display("FAIL %s irq_fall got=%b required=0", tag, irq); end
    axi_read(4'hC, d, r);
    tot++; if (d !== 32'h0) begin bad++; $display("FAIL %s status_clr got=%h required=0", tag, d); end
  endtask

  task automatic test_irq_measure();
    measure(5, 10, "meas100");
  endtask

  task automatic test_random_measure();
    for (int i = 0; i < 4; i++) begin
      measure(int'($urandom_range(2, 6)), int'($urandom_range(1, 9)), "meas_rand");
    end
    sens_half = 0;
  endtask

  task automatic test_ro_write();
    logic [31:0] d;
    logic [1:0]  r, b;
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, b);
    tot++; if (b !== 2'b00) begin bad++; $display("FAIL ro_bresp got=%b required=00", b); end
    axi_read(4'h8, d, r);
    tot++; if (d !== m_result) begin bad++; $display("FAIL ro_result got=%h required=%h", d, m_result); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d;
    logic [1:0]  r, b;
    axi_write(4'h4, 32'h1122_3344, 4'hF, b);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0001, b);
    m_window = 32'h1122_33DD;
    axi_read(4'h4, d, r);
    tot++; if (d !== m_window) begin bad++; $display("FAIL wstrb got=%h required=%h", d, m_window); end
  endtask

  task automatic test_zero_window();
    logic [31:0] d;
    logic [1:0]  r, b;
    axi_write(4'h4, 32'h0, 4'hF, b);
    m_window = '0; m_result = '0;
    axi_write(4'h0, 32'h1, 4'hF, b);
    repeat (3) @(posedge aclk);
    axi_read(4'hC, d, r);
    tot++; if (d !== 32'h2) begin bad++; $display("FAIL zero_status got=%h required=2", d); end
    axi_read(4'h8, d, r);
    tot++; if (d !== m_result) begin bad++; $display("FAIL zero_result got=%h required=0", d); end
    tot++; if (irq !== 1'b0) begin bad++; $display("FAIL zero_irq got=%b required=0", irq); end
    axi_write(4'hC, 32'h2, 4'hF, b);
  endtask

  task automatic test_valid_behaviour();
    logic        seen, held;
    logic [31:0] val, snap;
    val = $urandom;
    @(negedge aclk);
    awaddr = 4'h4; wdata = val; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin #1; seen |= awready | wready; @(negedge aclk); end
    tot++; if (seen !== 1'b0) begin bad++; $display("FAIL aw_stall got=%b required=0", seen); end
    wvalid = 1'b1;
    #1;
    tot++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL aw_accept got=%b required=11", {awready, wready}); end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    m_window = val;
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin held &= bvalid; @(posedge aclk); #1; end
    tot++; if (held !== 1'b1) begin bad++; $display("FAIL bvalid_hold got=%b required=1", held); end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    tot++; if (bvalid !== 1'b0) begin bad++; $display("FAIL bvalid_drop got=%b required=0", bvalid); end
    @(negedge aclk);
    araddr = 4'h4; arvalid = 1'b1;
    #1;
    tot++; if (arready !== 1'b1) begin bad++; $display("FAIL ar_accept got=%b required=1", arready); end
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b0;
    snap = rdata;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge aclk); #1; held &= rvalid & (rdata === snap); end
    tot++; if (held !== 1'b1) begin bad++; $display("FAIL rvalid_hold got=%b required=1", held); end
    tot++; if (snap !== m_window) begin bad++; $display("FAIL rdata_val got=%h required=%h", snap, m_window); end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    tot++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_drop got=%b required=0", rvalid); end
  endtask

  task automatic test_continuous_reset();
    logic [31:0] d;
    logic [1:0]  r, b;
    int          n;
    axi_write(4'h4, 32'h8, 4'hF, b);
    axi_write(4'h0, 32'h5, 4'hF, b);
    n = 0; d = '0;
    while (d[1] !== 1'b1 && n < 20) begin axi_read(4'hC, d, r); n++; end
    tot++; if (d !== 32'h3) begin bad++; $display("FAIL cont_first got=%h required=3", d); end
    axi_write(4'hC, 32'h2, 4'hF, b);
    repeat (12) @(posedge aclk);
    axi_read(4'hC, d, r);
    tot++; if (d !== 32'h3) begin bad++; $display("FAIL cont_again got=%h required=3", d); end
    tot++; if (irq !== 1'b0) begin bad++; $display("FAIL cont_irq got=%b required=0", irq); end
    @(negedge aclk);
    araddr = 4'hC; arvalid = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    tot++; if (rvalid !== 1'b1) begin bad++; $display("FAIL pre_reset_rvalid got=%b required=1", rvalid); end
    @(posedge aclk); #1;
    areset = 1'b1; awaddr = 4'h0; wdata = 32'h5; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    tot++;
    if ({awready, wready, bvalid, arready, rvalid, rdata, irq} !== '0) begin
      bad++; $display("FAIL async_reset got=%h required=0", {awready, wready, bvalid, arready, rvalid, rdata, irq});
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    areset = 1'b0;
    m_window = '0; m_result = '0;
    axi_read(4'hC, d, r);
    tot++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_status got=%h required=0", d); end
    axi_read(4'h4, d, r);
    tot++; if (d !== m_window) begin bad++; $display("FAIL post_reset_window got=%h required=0", d); end
  endtask

  initial begin
    test_reset();
    test_rw_window();
    test_irq_measure();
    test_random_measure();
    test_ro_write();
    test_wstrb();
    test_zero_window();
    test_valid_behaviour();
    test_continuous_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
